pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall and flush controller for the seven-stage pipeline (PC, PF, IF, ID, EX, MEM1, MEM2, WB). It drives the write-enable and flush inputs of every inter-stage register. It merges these events into one consistent advance/hold/bubble decision per register per cycle:

- cache stalls,
- load-use hazards,
- multi-cycle divide occupancy,
- branch mispredicts,
- exception/eret redirects.

It also tracks redirects that arrive during an outstanding I-cache fetch, so stale instructions are discarded.

## Interface
Parameters:
- DIV_CYCLES, 32, cycles EX is held per divide (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- icache_stall  in  1  IF fetch not complete this cycle
- dcache_stall  in  1  MEM2 data access not complete this cycle
- load_use  in  1  ID instruction depends on load in EX
- div_start  in  1  EX holds a divide instruction
- exc_flush  in  1  exception/eret taken at MEM1; held by source until accepted
- bp_flush  in  1  branch in EX mispredicted; held by source until accepted
- PC_Wr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr  out  1 each  register write enables
- PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush  out  1 each  register flush (bubble); flush overrides write
- div_busy  out  1  EX held by divider

## Operation

State: fsm ∈ {RUN, DRAIN}, cnt (width clog2(DIV_CYCLES+1)), kill_if (1 bit). Outputs are combinational from state and inputs.

**Divide occupancy**
- div_busy = (div_start && cnt==0) || cnt>1.
- cnt loads DIV_CYCLES when div_start && cnt==0 && !dcache_stall.
- When cnt>1, cnt decrements.
- When cnt==1, cnt→0 only if EX_MEM1Wr=1; otherwise it holds at 1 to prevent a re-trigger.

**Priority each cycle (first match wins)**

Default: every Wr=1, every Flush=0.

1. dcache_stall:
   - PC..MEM1_MEM2 Wr=0, MEM2_Flush=1.
   - exc_flush and bp_flush are not accepted.
2. exc_flush (accepted):
   - PC_Wr=1.
   - PF/IF/ID/EX/MEM1_Flush=1.
   - MEM2_WBWr=1.
   - cnt←0, kill_if←0.
   - fsm←DRAIN if icache_stall, else RUN.
3. div_busy:
   - PC..ID_EX Wr=0, EX_Flush=1.
   - bp_flush is not accepted.
4. bp_flush (accepted):
   - PC_Wr=1, PF_Flush=1.
   - If load_use: IF_IDWr=0, ID_Flush=1, kill_if←1 (delay slot stays in IF_ID).
   - Else: IF_Flush=1, ID_EXWr=1.
   - fsm←DRAIN if icache_stall.
5. load_use: PC..IF_ID Wr=0, ID_Flush=1.
6. icache_stall or fsm==DRAIN: PC_Wr=0, PF_IFWr=0, IF_IDWr=0, IF_Flush=ID_EXWr.

**Front-end handling**
- kill_if: any cycle IF_IDWr would be 1 while kill_if=1 → IF_Flush=1 and kill_if←0.
- DRAIN additionally forces PF_Flush=1 and PC_Wr=0, which keeps the redirect target in PC.
- DRAIN exits to RUN in the first cycle with icache_stall=0. That cycle still uses the DRAIN outputs, so the stale fetch is discarded.
- Rules 1–5 apply unchanged in DRAIN for downstream registers.

**Reset (rst=0)**
- fsm=RUN, cnt=0, kill_if=0.
- All Wr=0, all Flush=0, div_busy=0.

## Timing
- Zero-cycle combinational response from inputs to outputs; state updates on the rising edge of clk.
- A divide issued at cycle t holds EX for cycles t..t+DIV_CYCLES-1 and advances at t+DIV_CYCLES, provided there is no dcache_stall.
- dcache_stall during a divide extends the hold; cnt does not re-arm.
- exc_flush during dcache_stall: deferred, then accepted in the first non-stalled cycle.
- bp_flush during div_busy: deferred.
- exc_flush and bp_flush in the same cycle: exc_flush wins and clears kill_if.
- Reset asserted mid-DRAIN or mid-divide: state is cleared on the next edge.

## Test plan
- Idle, all inputs 0 → every Wr=1, every Flush=0. Reset held 3 cycles → all outputs 0.
- DIV_CYCLES=4, div_start held at t:
  - ID_EXWr=0 and EX_Flush=1 for t..t+3.
  - EX_MEM1Wr=1 at t+4, cnt=0 at t+5, no re-trigger.
- Divide with dcache_stall during t+3..t+5 → cnt holds at 1; EX advances at the first non-stalled cycle; cnt is never reloaded.
- bp_flush with load_use=1 → PF_Flush=1, IF_IDWr=0, ID_Flush=1, kill_if=1. On the next IF_ID write, IF_Flush=1 and kill_if returns to 0.
- exc_flush with icache_stall=1 for 3 more cycles:
  - Flushes PF..MEM1 and PC_Wr=1.
  - DRAIN for 4 cycles with PF_Flush=1 and PC_Wr=0.
  - RUN on the 5th cycle.
- exc_flush and dcache_stall together for 2 cycles → no flush until dcache_stall=0, then all front flushes asserted in that cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush controller for the eight-register pipeline
// (PC, PF, IF, ID, EX, MEM1, MEM2, WB). Each cycle it merges cache stalls,
// load-use hazards, divider occupancy, branch mispredicts and exception/eret
// redirects into one advance/hold/bubble decision per inter-stage register.
// It also discards instructions from an I-cache fetch that was outstanding
// when a redirect arrived.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   icache_stall        IF fetch not complete this cycle
//   dcache_stall        MEM2 data access not complete this cycle
//   load_use            ID instruction depends on the load in EX
//   div_start           EX holds a divide instruction
//   exc_flush           exception/eret redirect from MEM1 (held until taken)
//   bp_flush            branch mispredict from EX (held until taken)
//   *Wr                 per-register write enables
//   *_Flush             per-register bubble insert (overrides write)
//   div_busy            EX is held by the divider
//
// Outputs are combinational from the current state and inputs.
// ----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic icache_stall,
    input  logic dcache_stall,
    input  logic load_use,
    input  logic div_start,
    input  logic exc_flush,
    input  logic bp_flush,
    output logic PC_Wr,
    output logic PF_IFWr,
    output logic IF_IDWr,
    output logic ID_EXWr,
    output logic EX_MEM1Wr,
    output logic MEM1_MEM2Wr,
    output logic MEM2_WBWr,
    output logic PF_Flush,
    output logic IF_Flush,
    output logic ID_Flush,
    output logic EX_Flush,
    output logic MEM1_Flush,
    output logic MEM2_Flush,
    output logic div_busy
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_kill_if;
    logic             w_kill_if_nxt;

    logic w_cnt_zero;
    logic w_cnt_one;
    logic w_cnt_gt1;
    logic w_div_busy;
    logic w_exc_acc;
    logic w_bp_acc;

    logic w_pc_wr;
    logic w_pf_if_wr;
    logic w_if_id_wr;
    logic w_id_ex_wr;
    logic w_ex_mem1_wr;
    logic w_mem1_mem2_wr;
    logic w_mem2_wb_wr;
    logic w_pf_flush;
    logic w_if_flush;
    logic w_id_flush;
    logic w_ex_flush;
    logic w_mem1_flush;
    logic w_mem2_flush;

    // Divider occupancy decode
    always_comb begin
        w_cnt_zero = (r_cnt == '0);
        w_cnt_one  = (r_cnt == CNT_W'(1));
        w_cnt_gt1  = (r_cnt > CNT_W'(1));
        w_div_busy = (div_start && w_cnt_zero) || w_cnt_gt1;
    end

    // Priority merge of hazard/redirect events into per-register controls
    always_comb begin
        w_pc_wr        = 1'b1;
        w_pf_if_wr     = 1'b1;
        w_if_id_wr     = 1'b1;
        w_id_ex_wr     = 1'b1;
        w_ex_mem1_wr   = 1'b1;
        w_mem1_mem2_wr = 1'b1;
        w_mem2_wb_wr   = 1'b1;
        w_pf_flush     = 1'b0;
        w_if_flush     = 1'b0;
        w_id_flush     = 1'b0;
        w_ex_flush     = 1'b0;
        w_mem1_flush   = 1'b0;
        w_mem2_flush   = 1'b0;
        w_exc_acc      = 1'b0;
        w_bp_acc       = 1'b0;

        if (dcache_stall) begin
            // Whole pipe up to MEM2 freezes; redirects wait for a free cycle
            w_pc_wr        = 1'b0;
            w_pf_if_wr     = 1'b0;
            w_if_id_wr     = 1'b0;
            w_id_ex_wr     = 1'b0;
            w_ex_mem1_wr   = 1'b0;
            w_mem1_mem2_wr = 1'b0;
            w_mem2_flush   = 1'b1;
        end else if (exc_flush) begin
            w_exc_acc    = 1'b1;
            w_pc_wr      = 1'b1;
            w_pf_flush   = 1'b1;
            w_if_flush   = 1'b1;
            w_id_flush   = 1'b1;
            w_ex_flush   = 1'b1;
            w_mem1_flush = 1'b1;
            w_mem2_wb_wr = 1'b1;
        end else if (w_div_busy) begin
            w_pc_wr    = 1'b0;
            w_pf_if_wr = 1'b0;
            w_if_id_wr = 1'b0;
            w_id_ex_wr = 1'b0;
            w_ex_flush = 1'b1;
        end else if (bp_flush) begin
            w_bp_acc   = 1'b1;
            w_pc_wr    = 1'b1;
            w_pf_flush = 1'b1;
            if (load_use) begin
                // Delay slot waits in IF_ID; its stale successor is killed later
                w_if_id_wr = 1'b0;
                w_id_flush = 1'b1;
            end else begin
                w_if_flush = 1'b1;
                w_id_ex_wr = 1'b1;
            end
        end else if (load_use) begin
            w_pc_wr    = 1'b0;
            w_pf_if_wr = 1'b0;
            w_if_id_wr = 1'b0;
            w_id_flush = 1'b1;
        end else if (icache_stall || (r_state == ST_DRAIN)) begin
            w_pc_wr    = 1'b0;
            w_pf_if_wr = 1'b0;
            w_if_id_wr = 1'b0;
            w_if_flush = w_id_ex_wr;
        end

        // Pending kill: the first instruction written into IF_ID is stale
        if (r_kill_if && w_if_id_wr) begin
            w_if_flush = 1'b1;
        end

        // Draining a stale fetch: hold the redirect target, drop PF contents
        if ((r_state == ST_DRAIN) && !w_exc_acc && !w_bp_acc) begin
            w_pf_flush = 1'b1;
            w_pc_wr    = 1'b0;
        end
    end

    // Next-state logic for fetch FSM, divide counter and kill flag
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_kill_if_nxt = r_kill_if;

        if (!icache_stall) begin
            w_state_nxt = ST_RUN;
        end else if (w_exc_acc || w_bp_acc) begin
            w_state_nxt = ST_DRAIN;
        end

        if (w_exc_acc) begin
            w_cnt_nxt = '0;
        end else if (div_start && w_cnt_zero && !dcache_stall) begin
            w_cnt_nxt = CNT_W'(DIV_CYCLES);
        end else if (w_cnt_gt1) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_cnt_one && w_ex_mem1_wr) begin
            // Parks at 1 until EX drains, so a held div_start cannot re-arm
            w_cnt_nxt = '0;
        end

        if (r_kill_if && w_if_id_wr) begin
            w_kill_if_nxt = 1'b0;
        end
        if (w_bp_acc && load_use) begin
            w_kill_if_nxt = 1'b1;
        end
        if (w_exc_acc) begin
            w_kill_if_nxt = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_kill_if <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_kill_if <= w_kill_if_nxt;
        end
    end

    // All controls are forced low while reset is asserted
    always_comb begin
        PC_Wr       = rst & w_pc_wr;
        PF_IFWr     = rst & w_pf_if_wr;
        IF_IDWr     = rst & w_if_id_wr;
        ID_EXWr     = rst & w_id_ex_wr;
        EX_MEM1Wr   = rst & w_ex_mem1_wr;
        MEM1_MEM2Wr = rst & w_mem1_mem2_wr;
        MEM2_WBWr   = rst & w_mem2_wb_wr;
        PF_Flush    = rst & w_pf_flush;
        IF_Flush    = rst & w_if_flush;
        ID_Flush    = rst & w_id_flush;
        EX_Flush    = rst & w_ex_flush;
        MEM1_Flush  = rst & w_mem1_flush;
        MEM2_Flush  = rst & w_mem2_flush;
        div_busy    = rst & w_div_busy;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
// Scenario bench for pipe_ctrl (DIV_CYCLES=4). Each scenario drives one
// input vector per cycle, pushes the expected output vector into a queue,
// then pops and compares it mid-cycle. Output vector layout:
//   {PC,PF_IF,IF_ID,ID_EX,EX_MEM1,MEM1_MEM2,MEM2_WB Wr,
//    PF,IF,ID,EX,MEM1,MEM2 Flush, div_busy}
// Input vector layout: {rst, icache, dcache, load_use, div_start, exc, bp}
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int unsigned DIVC = 4;

    localparam logic [6:0] I_IDLE   = 7'b1000000;
    localparam logic [6:0] I_RST    = 7'b0111111;
    localparam logic [6:0] I_DIV    = 7'b1000100;
    localparam logic [6:0] I_DIVD   = 7'b1010100;
    localparam logic [6:0] I_DIVI   = 7'b1100100;
    localparam logic [6:0] I_DIVBP  = 7'b1000101;
    localparam logic [6:0] I_BPLU   = 7'b1001001;
    localparam logic [6:0] I_LU     = 7'b1001000;
    localparam logic [6:0] I_ICH    = 7'b1100000;
    localparam logic [6:0] I_EXC    = 7'b1000010;
    localparam logic [6:0] I_EXCI   = 7'b1100010;
    localparam logic [6:0] I_EXCD   = 7'b1010010;
    localparam logic [6:0] I_EXBPLU = 7'b1001011;

    localparam logic [13:0] E_RST  = 14'b0000000_000000_0;
    localparam logic [13:0] E_IDLE = 14'b1111111_000000_0;
    localparam logic [13:0] E_DIV  = 14'b0000111_000100_1;
    localparam logic [13:0] E_DST  = 14'b0000001_000001_0;
    localparam logic [13:0] E_DSTB = 14'b0000001_000001_1;
    localparam logic [13:0] E_EXC  = 14'b1111111_111110_0;
    localparam logic [13:0] E_BP   = 14'b1111111_110000_0;
    localparam logic [13:0] E_BPLU = 14'b1101111_101000_0;
    localparam logic [13:0] E_LU   = 14'b0001111_001000_0;
    localparam logic [13:0] E_IST  = 14'b0001111_010000_0;
    localparam logic [13:0] E_DRN  = 14'b0001111_110000_0;
    localparam logic [13:0] E_KILL = 14'b1111111_010000_0;
    localparam logic [13:0] E_DDRN = 14'b0000111_100100_1;

    logic clk;
    logic rst;
    logic icache_stall, dcache_stall, load_use, div_start, exc_flush, bp_flush;
    logic PC_Wr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr;
    logic PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush;
    logic div_busy;
    logic [13:0] obs;

    logic [13:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    pipe_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .clk         (clk),
        .rst         (rst),
        .icache_stall(icache_stall),
        .dcache_stall(dcache_stall),
        .load_use    (load_use),
        .div_start   (div_start),
        .exc_flush   (exc_flush),
        .bp_flush    (bp_flush),
        .PC_Wr       (PC_Wr),
        .PF_IFWr     (PF_IFWr),
        .IF_IDWr     (IF_IDWr),
        .ID_EXWr     (ID_EXWr),
        .EX_MEM1Wr   (EX_MEM1Wr),
        .MEM1_MEM2Wr (MEM1_MEM2Wr),
        .MEM2_WBWr   (MEM2_WBWr),
        .PF_Flush    (PF_Flush),
        .IF_Flush    (IF_Flush),
        .ID_Flush    (ID_Flush),
        .EX_Flush    (EX_Flush),
        .MEM1_Flush  (MEM1_Flush),
        .MEM2_Flush  (MEM2_Flush),
        .div_busy    (div_busy)
    );

    assign obs = {PC_Wr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr,
                  PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush, div_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input vector just after the rising edge and queue its expectation
    task automatic drive(input logic [6:0] v, input logic [13:0] e);
        @(posedge clk);
        #1;
        {rst, icache_stall, dcache_stall, load_use, div_start, exc_flush, bp_flush} = v;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [6:0]  iv [6] = '{I_RST, I_RST, I_RST, I_IDLE, I_IDLE, I_IDLE};
        logic [13:0] ev [6] = '{E_RST, E_RST, E_RST, E_IDLE, E_IDLE, E_IDLE};
        logic [13:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(iv[i], ev[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL reset[%0d] outputs got=%b exp=%b", i, obs, e);
            end
        end
        n_checks++;
        if ((int'(dut.r_cnt) !== 0) || (dut.r_kill_if !== 1'b0)) begin
            n_errors++;
            $display("FAIL reset_state got cnt=%0d kill=%b exp cnt=0 kill=0", dut.r_cnt, dut.r_kill_if);
        end
    endtask

    task automatic test_icache();
        logic [6:0]  iv [3] = '{I_ICH, I_LU, I_IDLE};
        logic [13:0] ev [3] = '{E_IST, E_LU, E_IDLE};
        logic [13:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(iv[i], ev[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL icache[%0d] outputs got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_divide();
        logic [6:0]  iv [7] = '{I_DIV, I_DIV, I_DIV, I_DIV, I_DIV, I_IDLE, I_IDLE};
        logic [13:0] ev [7] = '{E_DIV, E_DIV, E_DIV, E_DIV, E_IDLE, E_IDLE, E_IDLE};
        int          cv [7] = '{0, 4, 3, 2, 1, 0, 0};
        logic [13:0] e;
        for (int i = 0; i < 7; i++) begin
            drive(iv[i], ev[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL divide[%0d] outputs got=%b exp=%b", i, obs, e);
            end
            n_checks++;
            if (int'(dut.r_cnt) !== cv[i]) begin
                n_errors++;
                $display("FAIL divide_cnt[%0d] got=%0d exp=%0d", i, dut.r_cnt, cv[i]);
            end
        end
    endtask

    task automatic test_div_dcache();
        logic [6:0]  iv [8] = '{I_DIV, I_DIV, I_DIV, I_DIVD, I_DIVD, I_DIVD, I_DIV, I_IDLE};
        logic [13:0] ev [8] = '{E_DIV, E_DIV, E_DIV, E_DSTB, E_DST, E_DST, E_IDLE, E_IDLE};
        int          cv [8] = '{0, 4, 3, 2, 1, 1, 1, 0};
        logic [13:0] e;
        for (int i = 0; i < 8; i++) begin
            drive(iv[i], ev[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL div_dcache[%0d] outputs got=%b exp=%b", i, obs, e);
            end
            n_checks++;
            if (int'(dut.r_cnt) !== cv[i]) begin
                n_errors++;
                $display("FAIL div_dcache_cnt[%0d] got=%0d exp=%0d", i, dut.r_cnt, cv[i]);
            end
        end
    endtask

    task automatic test_bp_during_div();
        logic [6:0]  iv [6] = '{I_DIV, I_DIVBP, I_DIVBP, I_DIVBP, I_DIVBP, I_IDLE};
        logic [13:0] ev [6] = '{E_DIV, E_DIV, E_DIV, E_DIV, E_BP, E_IDLE};
        int          cv [6] = '{0, 4, 3, 2, 1, 0};
        logic [13:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(iv[i], ev[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL bp_during_div[%0d] outputs got=%b exp=%b", i, obs, e);
            end
            n_checks++;
            if (int'(dut.r_cnt) !== cv[i]) begin
                n_errors++;
                $display("FAIL bp_during_div_cnt[%0d] got=%0d exp=%0d", i, dut.r_cnt, cv[i]);
            end
        end
    endtask

    task automatic test_bp_load_use();
        logic [6:0]  iv [4] = '{I_BPLU, I_LU, I_IDLE, I_IDLE};
        logic [13:0] ev [4] = '{E_BPLU, E_LU, E_KILL, E_IDLE};
        logic        kv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [13:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(iv[i], ev[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL bp_load_use[%0d] outputs got=%b exp=%b", i, obs, e);
            end
            n_checks++;
            if (dut.r_kill_if !== kv[i]) begin
                n_errors++;
                $display("FAIL bp_load_use_kill[%0d] got=%b exp=%b", i, dut.r_kill_if, kv[i]);
            end
        end
    endtask

    task automatic test_exc_bp_same();
        logic [6:0]  iv [3] = '{I_BPLU, I_EXBPLU, I_IDLE};
        logic [13:0] ev [3] = '{E_BPLU, E_EXC, E_IDLE};
        logic        kv [3] = '{1'b0, 1'b1, 1'b0};
        logic [13:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(iv[i], ev[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL exc_bp_same[%0d] outputs got=%b exp=%b", i, obs, e);
            end
            n_checks++;
            if (dut.r_kill_if !== kv[i]) begin
                n_errors++;
                $display("FAIL exc_bp_same_kill[%0d] got=%b exp=%b", i, dut.r_kill_if, kv[i]);
            end
        end
    endtask

    task automatic test_exc_drain();
        logic [6:0]  iv [6] = '{I_EXCI, I_ICH, I_ICH, I_ICH, I_IDLE, I_IDLE};
        logic [13:0] ev [6] = '{E_EXC, E_DRN, E_DRN, E_DRN, E_DRN, E_IDLE};
        logic [13:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(iv[i], ev[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL exc_drain[%0d] outputs got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_exc_dcache();
        logic [6:0]  iv [4] = '{I_EXCD, I_EXCD, I_EXC, I_IDLE};
        logic [13:0] ev [4] = '{E_DST, E_DST, E_EXC, E_IDLE};
        logic [13:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(iv[i], ev[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL exc_dcache[%0d] outputs got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0]  iv [5] = '{I_EXCI, I_DIVI, I_RST, I_IDLE, I_IDLE};
        logic [13:0] ev [5] = '{E_EXC, E_DDRN, E_RST, E_IDLE, E_IDLE};
        int          cv [5] = '{-1, 0, 4, 0, 0};
        logic [13:0] e;
        for (int i = 0; i < 5; i++) begin
            drive(iv[i], ev[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL reset_mid[%0d] outputs got=%b exp=%b", i, obs, e);
            end
            if (cv[i] >= 0) begin
                n_checks++;
                if (int'(dut.r_cnt) !== cv[i]) begin
                    n_errors++;
                    $display("FAIL reset_mid_cnt[%0d] got=%0d exp=%0d", i, dut.r_cnt, cv[i]);
                end
            end
        end
    endtask

    initial begin
        {rst, icache_stall, dcache_stall, load_use, div_start, exc_flush, bp_flush} = I_RST;
        test_reset();
        test_icache();
        test_divide();
        test_div_dcache();
        test_bp_during_div();
        test_bp_load_use();
        test_exc_bp_same();
        test_exc_drain();
        test_exc_dcache();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
